// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway_if: controller access port and flush stream
// of the N-way set-associative data-cache storage array.
interface dcache_sram_nway_if #(
  parameter int SETS   = 16,
  parameter int WAYS   = 4,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
);
  localparam int IDX_W = $clog2(SETS);

  logic              enable_i;
  logic [IDX_W-1:0]  addr_i;
  logic [TAG_W+1:0]  tag_i;
  logic              write_i;
  logic [LINE_W-1:0] data_i;
  logic              hit_o;
  logic [TAG_W+1:0]  tag_o;
  logic [LINE_W-1:0] data_o;

  logic              flush_i;
  logic              flush_busy_o;
  logic              flush_valid_o;
  logic              flush_ready_i;
  logic [IDX_W-1:0]  flush_idx_o;
  logic [TAG_W-1:0]  flush_tag_o;
  logic [LINE_W-1:0] flush_data_o;
  logic              flush_done_o;

  modport master (
    output enable_i, addr_i, tag_i, write_i, data_i,
    output flush_i, flush_ready_i,
    input  hit_o, tag_o, data_o,
    input  flush_busy_o, flush_valid_o, flush_idx_o,
    input  flush_tag_o, flush_data_o, flush_done_o
  );

  modport slave (
    input  enable_i, addr_i, tag_i, write_i, data_i,
    input  flush_i, flush_ready_i,
    output hit_o, tag_o, data_o,
    output flush_busy_o, flush_valid_o, flush_idx_o,
    output flush_tag_o, flush_data_o, flush_done_o
  );
endinterface

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative line store with
// true-LRU ages, dirty tracking and a sequential flush engine.
module dcache_sram_nway #(
  parameter int SETS   = 16,
  parameter int WAYS   = 4,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) (
  input logic clk_i,
  input logic rst_i,
  dcache_sram_nway_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int PTR_W = IDX_W + AGE_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_e;

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             busy_q;
  logic             fvalid_q;
  logic             fdone_q;

  logic [IDX_W-1:0] set_a;
  logic [WAYS-1:0]  match;
  logic [WAYS-1:0]  inval;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] inv_way;
  logic [AGE_W-1:0] lru_way;
  logic [AGE_W-1:0] sel_way;
  logic [AGE_W-1:0] sel_age;
  logic             hit;

  logic             acc_en;
  logic             wr_en;
  logic             lru_en;
  logic             f_accept;

  logic [IDX_W-1:0] p_set;
  logic [AGE_W-1:0] p_way;
  logic             p_last;
  logic             p_dirty;

  logic             unused_vin;

  assign unused_vin = bus.tag_i[TAG_W+1];
  assign set_a      = bus.addr_i;

  // Tag compare, invalid-way and LRU-way search for the indexed set.
  always_comb begin
    match   = '0;
    inval   = '0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int k = 0; k < WAYS; k++) begin
      match[k] = valid_q[set_a][k] &&
                 (tag_q[set_a][k] == bus.tag_i[TAG_W-1:0]);
      inval[k] = !valid_q[set_a][k];
      if (age_q[set_a][k] == AGE_W'(WAYS - 1))
        lru_way = AGE_W'(k);
    end
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (match[k]) hit_way = AGE_W'(k);
      if (inval[k]) inv_way = AGE_W'(k);
    end
  end

  assign hit     = |match;
  assign sel_way = hit      ? hit_way :
                   (|inval) ? inv_way : lru_way;
  assign sel_age = age_q[set_a][sel_way];

  assign acc_en   = bus.enable_i && !busy_q && !bus.flush_i;
  assign wr_en    = acc_en && bus.write_i;
  assign lru_en   = acc_en && (hit || bus.write_i);
  assign f_accept = fvalid_q && bus.flush_ready_i;

  assign p_set   = ptr_q[PTR_W-1:AGE_W];
  assign p_way   = ptr_q[AGE_W-1:0];
  assign p_last  = &ptr_q;
  assign p_dirty = valid_q[p_set][p_way] && dirty_q[p_set][p_way];

  assign bus.hit_o  = hit && !busy_q;
  assign bus.tag_o  = {valid_q[set_a][sel_way],
                       dirty_q[set_a][sel_way],
                       tag_q[set_a][sel_way]};
  assign bus.data_o = data_q[set_a][sel_way];

  assign bus.flush_busy_o  = busy_q;
  assign bus.flush_valid_o = fvalid_q;
  assign bus.flush_done_o  = fdone_q;
  assign bus.flush_idx_o   = p_set;
  assign bus.flush_tag_o   = tag_q[p_set][p_way];
  assign bus.flush_data_o  = data_q[p_set][p_way];

  // Line store: writes, LRU age update and flush dirty clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int k = 0; k < WAYS; k++) begin
          valid_q[s][k] <= 1'b0;
          dirty_q[s][k] <= 1'b0;
          tag_q[s][k]   <= '0;
          data_q[s][k]  <= '0;
          age_q[s][k]   <= AGE_W'(k);
        end
      end
    end else begin
      if (wr_en) begin
        valid_q[set_a][sel_way] <= 1'b1;
        dirty_q[set_a][sel_way] <= bus.tag_i[TAG_W];
        tag_q[set_a][sel_way]   <= bus.tag_i[TAG_W-1:0];
        data_q[set_a][sel_way]  <= bus.data_i;
      end
      if (lru_en) begin
        for (int k = 0; k < WAYS; k++) begin
          if (AGE_W'(k) == sel_way)
            age_q[set_a][k] <= '0;
          else if (age_q[set_a][k] < sel_age)
            age_q[set_a][k] <= age_q[set_a][k] + 1'b1;
        end
      end
      if (f_accept)
        dirty_q[p_set][p_way] <= 1'b0;
    end
  end

  // Flush engine: scan every entry, stream out valid+dirty lines.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      fvalid_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.flush_i) begin
            state_q <= SCAN;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (p_dirty) begin
            state_q  <= EMIT;
            fvalid_q <= 1'b1;
          end else if (p_last) begin
            state_q <= DONE;
            fdone_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        EMIT: begin
          if (bus.flush_ready_i) begin
            fvalid_q <= 1'b0;
            if (p_last) begin
              state_q <= DONE;
              fdone_q <= 1'b1;
            end else begin
              state_q <= SCAN;
              ptr_q   <= ptr_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed table, flush corner cases and
// randomized accesses against a recency-list reference model.
module tb_dcache_sram_nway;
  localparam int SETS   = 16;
  localparam int WAYS   = 4;
  localparam int TAG_W  = 23;
  localparam int LINE_W = 256;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TW2    = TAG_W + 2;
  localparam int V      = 1 << (TAG_W + 1);
  localparam int D      = 1 << TAG_W;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  dcache_sram_nway_if #(
    .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)
  ) bus ();

  dcache_sram_nway #(
    .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [LINE_W-1:0] act,
                     logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-set recency list, most recent first.
  bit                m_v [SETS][WAYS];
  bit                m_d [SETS][WAYS];
  logic [TAG_W-1:0]  m_t [SETS][WAYS];
  logic [LINE_W-1:0] m_l [SETS][WAYS];
  int                m_ord [SETS][$];

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ord[s].delete();
      for (int k = 0; k < WAYS; k++) begin
        m_v[s][k] = 0;
        m_d[s][k] = 0;
        m_t[s][k] = '0;
        m_l[s][k] = '0;
        m_ord[s].push_back(k);
      end
    end
  endfunction

  function automatic int m_find(int s, logic [TAG_W-1:0] t,
                                output bit h);
    h = 0;
    for (int k = 0; k < WAYS; k++)
      if (m_v[s][k] && m_t[s][k] == t) begin
        h = 1;
        return k;
      end
    for (int k = 0; k < WAYS; k++)
      if (!m_v[s][k]) return k;
    return m_ord[s][WAYS-1];
  endfunction

  function automatic void m_touch(int s, int w);
    int pos;
    pos = 0;
    for (int i = 0; i < m_ord[s].size(); i++)
      if (m_ord[s][i] == w) pos = i;
    m_ord[s].delete(pos);
    m_ord[s].push_front(w);
  endfunction

  task automatic idle_inputs();
    bus.enable_i      = 1'b0;
    bus.write_i       = 1'b0;
    bus.addr_i        = '0;
    bus.tag_i         = '0;
    bus.data_i        = '0;
    bus.flush_i       = 1'b0;
    bus.flush_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_reset();
  endtask

  task automatic apply(int wr, int dty, int s, logic [TAG_W-1:0] t,
                       logic [LINE_W-1:0] d, logic eh,
                       logic [TW2-1:0] et, logic [LINE_W-1:0] ed,
                       string nm);
    bit h;
    int w;
    w = m_find(s, t, h);
    bus.enable_i = 1'b1;
    bus.write_i  = (wr != 0);
    bus.addr_i   = IDX_W'(s);
    bus.tag_i    = {1'b0, dty[0], t};
    bus.data_i   = d;
    #2;
    chk({nm, " hit"}, LINE_W'(bus.hit_o), LINE_W'(eh));
    chk({nm, " tag"}, LINE_W'(bus.tag_o), LINE_W'(et));
    chk({nm, " data"}, bus.data_o, ed);
    @(posedge clk_i); #1;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    if (wr != 0) begin
      m_v[s][w] = 1;
      m_d[s][w] = dty[0];
      m_t[s][w] = t;
      m_l[s][w] = d;
    end
    if (wr != 0 || h) m_touch(s, w);
  endtask

  task automatic acc(int wr, int dty, int s, logic [TAG_W-1:0] t,
                     logic [LINE_W-1:0] d, string nm);
    bit h;
    int w;
    w = m_find(s, t, h);
    apply(wr, dty, s, t, d, h,
          {m_v[s][w], m_d[s][w], m_t[s][w]}, m_l[s][w], nm);
  endtask

  // Start a flush, consume the stream, compare against the model.
  task automatic run_flush(int stall, int pct, int wr_too,
                           output int busy_cyc);
    int es[$];
    int ew[$];
    int n, stalled, dones, ndirty;
    bit fin, rdy;
    for (int s = 0; s < SETS; s++)
      for (int k = 0; k < WAYS; k++)
        if (m_v[s][k] && m_d[s][k]) begin
          es.push_back(s);
          ew.push_back(k);
        end
    ndirty = es.size();
    bus.flush_i = 1'b1;
    if (wr_too != 0) begin
      bus.enable_i = 1'b1;
      bus.write_i  = 1'b1;
      bus.addr_i   = IDX_W'(9);
      bus.tag_i    = {2'b01, TAG_W'('h33)};
      bus.data_i   = {8{32'h5555_aaaa}};
    end
    @(posedge clk_i); #1;
    idle_inputs();
    n = 0; stalled = 0; dones = 0; busy_cyc = 0; fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      rdy = 0;
      if (!bus.flush_busy_o) fin = 1;
      else busy_cyc++;
      if (bus.flush_done_o) dones++;
      if (bus.flush_valid_o) begin
        if (n < ndirty) begin
          chk("flush idx", LINE_W'(bus.flush_idx_o), LINE_W'(es[n]));
          chk("flush tag", LINE_W'(bus.flush_tag_o),
              LINE_W'(m_t[es[n]][ew[n]]));
          chk("flush data", bus.flush_data_o, m_l[es[n]][ew[n]]);
        end else begin
          chk("flush extra line", LINE_W'(n), LINE_W'(ndirty));
        end
        if (n == 0 && stalled < stall) stalled++;
        else rdy = ($urandom_range(99) < pct);
        if (rdy) n++;
      end
      bus.flush_ready_i = rdy;
      if (!fin) begin
        @(posedge clk_i); #1;
      end
    end
    bus.flush_ready_i = 1'b0;
    chk("flush terminated", LINE_W'(fin), LINE_W'(1));
    chk("flush line count", LINE_W'(n), LINE_W'(ndirty));
    chk("flush done pulses", LINE_W'(dones), LINE_W'(1));
    for (int s = 0; s < SETS; s++)
      for (int k = 0; k < WAYS; k++) m_d[s][k] = 0;
  endtask

  typedef struct {
    int wr; int dty; int s; int t; int d;
    int eh; int et; int ed;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int bc, nd, sel;
    logic [TAG_W-1:0] tg;

    tbl[0]  = '{0, 0, 3, 'h1, 0,     0, 0, 0};
    tbl[1]  = '{1, 0, 5, 'hA, 'h1A,  0, 0, 0};
    tbl[2]  = '{1, 0, 5, 'hB, 'h1B,  0, 0, 0};
    tbl[3]  = '{1, 0, 5, 'hC, 'h1C,  0, 0, 0};
    tbl[4]  = '{1, 0, 5, 'hD, 'h1D,  0, 0, 0};
    tbl[5]  = '{0, 0, 5, 'hA, 0,     1, V | 'hA, 'h1A};
    tbl[6]  = '{1, 0, 5, 'hE, 'h1E,  0, V | 'hB, 'h1B};
    tbl[7]  = '{0, 0, 5, 'hB, 0,     0, V | 'hC, 'h1C};
    tbl[8]  = '{0, 0, 5, 'hA, 0,     1, V | 'hA, 'h1A};
    tbl[9]  = '{1, 1, 5, 'hC, 'h2C,  1, V | 'hC, 'h1C};
    tbl[10] = '{0, 0, 5, 'hC, 0,     1, V | D | 'hC, 'h2C};
    tbl[11] = '{0, 0, 5, 'hF, 0,     0, V | 'hD, 'h1D};
    tbl[12] = '{0, 0, 5, 'hE, 0,     1, V | 'hE, 'h1E};
    tbl[13] = '{1, 0, 5, 'hF, 'h1F,  0, V | 'hD, 'h1D};

    do_reset();
    chk("reset busy", LINE_W'(bus.flush_busy_o), '0);
    chk("reset valid", LINE_W'(bus.flush_valid_o), '0);
    chk("reset done", LINE_W'(bus.flush_done_o), '0);

    for (int i = 0; i < 14; i++)
      apply(tbl[i].wr, tbl[i].dty, tbl[i].s, TAG_W'(tbl[i].t),
            LINE_W'(tbl[i].d), 1'(tbl[i].eh), TW2'(tbl[i].et),
            LINE_W'(tbl[i].ed), $sformatf("vec%0d", i));

    // Two dirty lines, first stalled for three cycles.
    do_reset();
    acc(1, 0, 0, 'h11, {8{32'h0000_0011}}, "fl w0");
    acc(1, 1, 0, 'h12, {8{32'h0000_0012}}, "fl w1");
    acc(1, 0, 15, 'h21, {8{32'h0000_0021}}, "fl w2");
    acc(1, 0, 15, 'h22, {8{32'h0000_0022}}, "fl w3");
    acc(1, 0, 15, 'h23, {8{32'h0000_0023}}, "fl w4");
    acc(1, 1, 15, 'h24, {8{32'h0000_0024}}, "fl w5");
    run_flush(3, 100, 0, bc);
    chk("flush duration", LINE_W'(bc), LINE_W'(SETS * WAYS + 2 + 3 + 1));
    apply(0, 0, 0, 'h12, '0, 1'b1, TW2'(V | 'h12),
          {8{32'h0000_0012}}, "post flush s0");
    apply(0, 0, 15, 'h24, '0, 1'b1, TW2'(V | 'h24),
          {8{32'h0000_0024}}, "post flush s15");

    // Reset while a line is being presented.
    acc(1, 1, 7, 'h77, {8{32'h0000_0077}}, "rst w");
    bus.flush_i = 1'b1;
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    for (int c = 0; c < 200 && !bus.flush_valid_o; c++) begin
      @(posedge clk_i); #1;
    end
    chk("emit reached", LINE_W'(bus.flush_valid_o), LINE_W'(1));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_reset();
    chk("rst emit busy", LINE_W'(bus.flush_busy_o), '0);
    chk("rst emit valid", LINE_W'(bus.flush_valid_o), '0);
    apply(0, 0, 7, 'h77, '0, 1'b0, '0, '0, "rst s7");
    apply(0, 0, 0, 'h12, '0, 1'b0, '0, '0, "rst s0");
    apply(0, 0, 15, 'h24, '0, 1'b0, '0, '0, "rst s15");

    // Flush and write in the same cycle: write dropped.
    run_flush(0, 100, 1, bc);
    chk("flush+wr duration", LINE_W'(bc), LINE_W'(SETS * WAYS + 1));
    apply(0, 0, 9, 'h33, '0, 1'b0, '0, '0, "dropped write");

    // Randomized accesses and flushes against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(4);
      tg  = TAG_W'($urandom_range(5));
      acc($urandom_range(1), $urandom_range(1),
          (sel == 4) ? 15 : sel, tg, {8{$urandom}},
          $sformatf("rnd%0d", i));
      if (i % 100 == 99) begin
        nd = 0;
        for (int s = 0; s < SETS; s++)
          for (int k = 0; k < WAYS; k++)
            if (m_v[s][k] && m_d[s][k]) nd++;
        if ((i / 100) % 2 == 0) begin
          run_flush(0, 100, 0, bc);
          chk("rnd flush duration", LINE_W'(bc),
              LINE_W'(SETS * WAYS + nd + 1));
        end else begin
          run_flush(0, 50, 0, bc);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_sram_nway.md
Name: dcache_sram_nway

Overview:
Parametrised N-way set-associative data-cache storage array with true-LRU replacement. It is the successor to the fixed 2-way/16-set array and sits between the dcache controller and the line store. Set count, way count, tag width and line width are parameters. It adds a controller-visible dirty bit on writes and a sequential flush engine that streams every valid+dirty line out over a valid/ready port.

Parameters:
SETS, 16, number of sets; power of two, >=2
WAYS, 4, associativity; power of two, 2..8
TAG_W, 23, address tag width excluding valid/dirty
LINE_W, 256, line width in bits
(derived) IDX_W = log2(SETS), AGE_W = log2(WAYS)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
enable_i  in  1  access strobe
addr_i  in  IDX_W  set index
tag_i  in  TAG_W+2  [TAG_W+1]=valid (ignored on input), [TAG_W]=dirty, [TAG_W-1:0]=tag
write_i  in  1  write the selected way (with enable_i)
data_i  in  LINE_W  write line
hit_o  out  1  tag match in an indexed valid way
tag_o  out  TAG_W+2  {valid,dirty,tag} of the selected way
data_o  out  LINE_W  line of the selected way
flush_i  in  1  start flush (pulse)
flush_busy_o  out  1  flush engine active
flush_valid_o  out  1  dirty line presented
flush_ready_i  in  1  consumer accepts line
flush_idx_o  out  IDX_W  set of presented line
flush_tag_o  out  TAG_W  tag of presented line
flush_data_o  out  LINE_W  presented line
flush_done_o  out  1  one-cycle pulse at flush completion

Behaviour:
- Reset (sync, rst_i high at edge): all valid/dirty/tag/data cleared; per-set age of way k = k (way WAYS-1 is LRU); FSM to IDLE; flush_busy_o, flush_valid_o and flush_done_o are 0. Reset wins over every other input, including mid-flush.
- Lookup is combinational: hit_way = lowest-index way with valid && tag match; hit_o = any match (0 while flush_busy_o).
- Selected way: the hit way; else the lowest-index invalid way; else the way with age WAYS-1 (LRU). tag_o and data_o show the selected way, with zero added latency.
- Write (enable_i && write_i, not busy): the selected way gets data_i and tag; valid is set to 1; dirty = tag_i[TAG_W]. Clean refill is therefore dirty=0 and write-hit is dirty=1. The controller must read tag_o/data_o for the victim before the write edge.
- LRU update on any enabled access that hits, and on any write: accessed way w with old age a gets age 0; every way in the set with age < a increments; the others are unchanged. A read miss leaves ages unchanged. Ages within a set always remain a permutation of 0..WAYS-1.
- FSM states:
  - IDLE: flush_i moves to SCAN with ptr={set 0, way 0}. If flush_i and enable_i are high together, the flush starts and the access is dropped.
  - SCAN: examines one entry per cycle. If the entry is valid && dirty, move to EMIT. Otherwise advance ptr (way first, then set). After the last entry, move to DONE.
  - EMIT: flush_valid_o=1. flush_idx_o, flush_tag_o and flush_data_o hold stable until flush_ready_i. On a cycle where flush_valid_o && flush_ready_i are both high, clear that entry's dirty bit, advance ptr, and go to SCAN, or to DONE after the last entry.
  - DONE: flush_done_o=1 for one cycle, then return to IDLE.
- flush_busy_o = state != IDLE. While busy: enable_i and flush_i are ignored and LRU is frozen. Flushed lines stay valid and become clean.
- Flush duration with no backpressure is SETS*WAYS + (#dirty lines) + 1 cycles.

Test Plan:
- Reset, then a read of set 3 tag 0x1 -> hit_o=0, tag_o=0, data_o=0, flush_busy_o=0.
- Fill set 5 with tags A,B,C,D (writes, dirty=0), then read A; write E (miss) -> E replaces B (LRU); a later read of B misses and read of A hits.
- Write-hit on C with dirty=1 -> tag_o dirty=1 and data updated; ages for set 5 become C=0, with ways younger than C's old age each incremented.
- Two dirty lines (set 0 way 1, set 15 way 3) + flush_i, flush_ready_i low for 3 cycles on the first -> outputs stable while stalled; lines emitted in order (0,1), then (15,3); flush_done_o pulses once; both lines are afterwards valid and clean.
- rst_i asserted during EMIT -> next cycle flush_busy_o=0, flush_valid_o=0, all lines invalid.
- flush_i and enable_i/write_i asserted in the same cycle -> the write is dropped (a later read misses) and the flush runs.
